// File: rtl/mem_lb_pkg.sv
// Shared types and constants for the MEM_LB round-robin arbiter.
package mem_lb_pkg;

   localparam int unsigned LB_ADR_W     = 32;
   localparam int unsigned LB_LEN_W     = 8;
   localparam int unsigned LB_IDX_W     = 3;
   localparam int unsigned LB_MAX_PORTS = 8;
   localparam int unsigned LB_TMO_DEF   = 4096;
   localparam int unsigned LB_CNT_MIN_W = 13;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DATA = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   typedef struct packed {
      logic [LB_ADR_W-1:0] adr;
      logic [LB_LEN_W-1:0] len;
   } lb_req_t;

endpackage

// File: rtl/mem_lb_rr_arb_rr_pick.sv
// Round-robin pick: first set request searching upward from last+1, wrapping.
module rr_pick
   import mem_lb_pkg::*;
#(
   parameter int unsigned P_PORTS = 4
) (
   input  logic [P_PORTS-1:0]  req,
   input  logic [LB_IDX_W-1:0] last,
   output logic                vld_c,
   output logic [LB_IDX_W-1:0] idx_c
);

   logic [LB_MAX_PORTS-1:0] req_pad;
   logic [LB_IDX_W:0]       sum;

   // Zero-extend so a full-width index never runs past the vector
   assign req_pad = LB_MAX_PORTS'(req);

   // Walk candidates last+1 .. last+P_PORTS modulo P_PORTS, keep the first hit
   always_comb begin
      vld_c = 1'b0;
      idx_c = '0;
      sum   = '0;
      for (int i = 1; i <= int'(P_PORTS); i++) begin
         sum = {1'b0, last} + (LB_IDX_W+1)'(i);
         if (sum >= (LB_IDX_W+1)'(P_PORTS)) begin
            sum = sum - (LB_IDX_W+1)'(P_PORTS);
         end
         if (!vld_c && req_pad[sum[LB_IDX_W-1:0]]) begin
            vld_c = 1'b1;
            idx_c = sum[LB_IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/mem_lb_rr_arb.sv
// Round-robin arbiter sharing one MEM_LB read port among P_PORTS requesters.
module mem_lb_rr_arb
   import mem_lb_pkg::*;
#(
   parameter int unsigned P_PORTS = 4,
   parameter int unsigned P_DAT_W = 512,
   parameter int unsigned P_TMO   = LB_TMO_DEF
) (
   input  logic                         CLK,
   input  logic                         RST_N,
   input  logic [P_PORTS-1:0]           REQ_I,
   input  logic [P_PORTS*LB_ADR_W-1:0]  ADR_I,
   input  logic [P_PORTS*LB_LEN_W-1:0]  LEN_I,
   output logic [P_PORTS-1:0]           ACK_O,
   output logic [P_PORTS-1:0]           WREN_O,
   output logic [P_DAT_W-1:0]           WDAT_O,
   output logic [P_PORTS-1:0]           WEND_O,
   output logic                         MEM_LB_REQ,
   output logic [LB_ADR_W-1:0]          MEM_LB_ADR,
   output logic [LB_LEN_W-1:0]          MEM_LB_LEN,
   input  logic                         MEM_LB_ACK,
   input  logic                         MEM_LB_WREN,
   input  logic [P_DAT_W-1:0]           MEM_LB_WDAT,
   input  logic                         MEM_LB_WEND,
   output logic [LB_IDX_W-1:0]          GNT_ID,
   output logic                         BUSY,
   output logic                         TMO_ERR
);

   localparam int unsigned CNT_W = ($clog2(P_TMO) + 1 > LB_CNT_MIN_W) ?
                                   ($clog2(P_TMO) + 1) : LB_CNT_MIN_W;

   state_t               state_q, state_nxt;
   lb_req_t              lb_q, lb_sel;
   logic [LB_IDX_W-1:0]  gnt_q, last_q, pick_idx;
   logic                 pick_vld;
   logic                 mem_req_q, busy_q, tmo_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [P_PORTS-1:0]   gnt_oh;
   logic                 grant, ack_c, dat_act, done, tmo_hit;

   rr_pick #(.P_PORTS(P_PORTS)) u_pick (
      .req   (REQ_I),
      .last  (last_q),
      .vld_c (pick_vld),
      .idx_c (pick_idx)
   );

   // Mux the winning requester's address/length
   always_comb begin
      lb_sel = '0;
      for (int k = 0; k < int'(P_PORTS); k++) begin
         if (pick_idx == LB_IDX_W'(k)) begin
            lb_sel.adr = ADR_I[LB_ADR_W*k +: LB_ADR_W];
            lb_sel.len = LB_LEN_W'(LEN_I[LB_LEN_W*k +: LB_LEN_W]);
         end
      end
   end

   // Next-state and per-cycle strobes
   always_comb begin
      state_nxt = state_q;
      grant     = 1'b0;
      ack_c     = 1'b0;
      dat_act   = 1'b0;
      done      = 1'b0;
      tmo_hit   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               grant     = 1'b1;
               state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            if (MEM_LB_ACK) begin
               ack_c = 1'b1;
               if (lb_q.len != '0) begin
                  state_nxt = ST_DATA;
               end else begin
                  done      = 1'b1;
                  state_nxt = ST_GAP;
               end
            end
         end
         ST_DATA: begin
            dat_act = 1'b1;
            if (MEM_LB_WEND) begin
               done      = 1'b1;
               state_nxt = ST_GAP;
            end else if (cnt_q == CNT_W'(P_TMO - 1)) begin
               tmo_hit   = 1'b1;
               done      = 1'b1;
               state_nxt = ST_GAP;
            end
         end
         ST_GAP: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and control registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_IDLE;
         lb_q      <= '0;
         gnt_q     <= '0;
         last_q    <= LB_IDX_W'(P_PORTS - 1);
         mem_req_q <= 1'b0;
         busy_q    <= 1'b0;
         tmo_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_nxt;
         mem_req_q <= (state_nxt == ST_REQ);
         busy_q    <= (state_nxt != ST_IDLE);
         if (grant) begin
            gnt_q <= pick_idx;
            lb_q  <= lb_sel;
         end
         if (done) begin
            last_q <= gnt_q;
         end
         if (tmo_hit) begin
            tmo_q <= 1'b1;
         end
         if (state_q == ST_DATA) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end else begin
            cnt_q <= '0;
         end
      end
   end

   // Zero-latency response steering to the granted requester
   assign gnt_oh     = P_PORTS'(1) << gnt_q;
   assign ACK_O      = ack_c ? gnt_oh : '0;
   assign WREN_O     = (dat_act && MEM_LB_WREN) ? gnt_oh : '0;
   assign WEND_O     = (dat_act && MEM_LB_WEND) ? gnt_oh : '0;
   assign WDAT_O     = MEM_LB_WDAT;
   assign MEM_LB_REQ = mem_req_q;
   assign MEM_LB_ADR = lb_q.adr;
   assign MEM_LB_LEN = lb_q.len;
   assign GNT_ID     = gnt_q;
   assign BUSY       = busy_q;
   assign TMO_ERR    = tmo_q;

endmodule

// File: tb/tb_mem_lb_rr_arb.sv
// Scoreboard bench for mem_lb_rr_arb: grant order, data steering, timeout, reset.
module tb_mem_lb_rr_arb;

   localparam int unsigned NP  = 4;
   localparam int unsigned DW  = 64;
   localparam int unsigned TMO = 16;

   logic             CLK = 1'b0;
   logic             RST_N;
   logic [NP-1:0]    REQ_I;
   logic [NP*32-1:0] ADR_I;
   logic [NP*8-1:0]  LEN_I;
   logic [NP-1:0]    ACK_O, WREN_O, WEND_O;
   logic [DW-1:0]    WDAT_O;
   logic             MEM_LB_REQ;
   logic [31:0]      MEM_LB_ADR;
   logic [7:0]       MEM_LB_LEN;
   logic             MEM_LB_ACK, MEM_LB_WREN, MEM_LB_WEND;
   logic [DW-1:0]    MEM_LB_WDAT;
   logic [2:0]       GNT_ID;
   logic             BUSY, TMO_ERR;

   typedef struct {
      int          port;
      logic [31:0] adr;
      logic [7:0]  len;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   mem_lb_rr_arb #(.P_PORTS(NP), .P_DAT_W(DW), .P_TMO(TMO)) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .REQ_I       (REQ_I),
      .ADR_I       (ADR_I),
      .LEN_I       (LEN_I),
      .ACK_O       (ACK_O),
      .WREN_O      (WREN_O),
      .WDAT_O      (WDAT_O),
      .WEND_O      (WEND_O),
      .MEM_LB_REQ  (MEM_LB_REQ),
      .MEM_LB_ADR  (MEM_LB_ADR),
      .MEM_LB_LEN  (MEM_LB_LEN),
      .MEM_LB_ACK  (MEM_LB_ACK),
      .MEM_LB_WREN (MEM_LB_WREN),
      .MEM_LB_WDAT (MEM_LB_WDAT),
      .MEM_LB_WEND (MEM_LB_WEND),
      .GNT_ID      (GNT_ID),
      .BUSY        (BUSY),
      .TMO_ERR     (TMO_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Program one requester and queue the transaction it should produce
   task automatic setup_port(input int p, input logic [31:0] a, input logic [7:0] l);
      exp_t e;
      ADR_I[32*p +: 32] = a;
      LEN_I[8*p +: 8]   = l;
      e.port = p;
      e.adr  = a;
      e.len  = l;
      exp_q.push_back(e);
   endtask

   // Act as the memory: wait for a request, ack it, stream beats
   task automatic serve(input int ack_dly, input int nbeats, input bit do_wend, input bit drop);
      exp_t          e;
      int            n;
      logic [NP-1:0] oh;
      logic [DW-1:0] d;
      n = 0;
      while (MEM_LB_REQ !== 1'b1 && n < 32) begin
         tick();
         n++;
      end
      checks++;
      if (MEM_LB_REQ !== 1'b1) begin
         errors++;
         $display("FAIL req_wait: MEM_LB_REQ=%b after %0d cycles, want 1", MEM_LB_REQ, n);
         return;
      end
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL sb_empty: unexpected request adr=%h, want none", MEM_LB_ADR);
         return;
      end
      e  = exp_q.pop_front();
      oh = NP'(1) << e.port;
      checks++;
      if (GNT_ID !== 3'(e.port)) begin
         errors++;
         $display("FAIL gnt_id: got %0d want %0d", GNT_ID, e.port);
      end
      checks++;
      if (MEM_LB_ADR !== e.adr || MEM_LB_LEN !== e.len) begin
         errors++;
         $display("FAIL adr_len: got %h/%0d want %h/%0d", MEM_LB_ADR, MEM_LB_LEN, e.adr, e.len);
      end
      repeat (ack_dly) begin
         tick();
         checks++;
         if (MEM_LB_REQ !== 1'b1 || MEM_LB_ADR !== e.adr) begin
            errors++;
            $display("FAIL req_stable: req=%b adr=%h want 1/%h", MEM_LB_REQ, MEM_LB_ADR, e.adr);
         end
      end
      MEM_LB_ACK = 1'b1;
      #1;
      checks++;
      if (ACK_O !== oh) begin
         errors++;
         $display("FAIL ack_o: got %b want %b", ACK_O, oh);
      end
      tick();
      MEM_LB_ACK = 1'b0;
      if (drop) REQ_I[e.port] = 1'b0;
      #1;
      checks++;
      if (MEM_LB_REQ !== 1'b0 || ACK_O !== '0) begin
         errors++;
         $display("FAIL req_drop: req=%b ack=%b want 0/0", MEM_LB_REQ, ACK_O);
      end
      for (int b = 0; b < nbeats; b++) begin
         d           = {$urandom, $urandom};
         MEM_LB_WREN = 1'b1;
         MEM_LB_WDAT = d;
         MEM_LB_WEND = do_wend && (b == nbeats - 1);
         #1;
         checks++;
         if (WREN_O !== oh || WDAT_O !== d || WEND_O !== (MEM_LB_WEND ? oh : '0)) begin
            errors++;
            $display("FAIL beat%0d: wren=%b wend=%b dat=%h want %b/%b/%h", b, WREN_O, WEND_O,
                     WDAT_O, oh, (MEM_LB_WEND ? oh : '0), d);
         end
         tick();
      end
      MEM_LB_WREN = 1'b0;
      MEM_LB_WEND = 1'b0;
   endtask

   task automatic check_idle_outputs(input string name);
      checks++;
      if (BUSY !== 1'b0 || GNT_ID !== 3'd0 || TMO_ERR !== 1'b0 || MEM_LB_REQ !== 1'b0 ||
          MEM_LB_ADR !== 32'd0 || MEM_LB_LEN !== 8'd0 || ACK_O !== '0 || WREN_O !== '0 ||
          WEND_O !== '0) begin
         errors++;
         $display("FAIL %s: busy=%b gnt=%0d tmo=%b req=%b adr=%h len=%0d ack=%b wren=%b wend=%b want all 0",
                  name, BUSY, GNT_ID, TMO_ERR, MEM_LB_REQ, MEM_LB_ADR, MEM_LB_LEN, ACK_O, WREN_O, WEND_O);
      end
   endtask

   task automatic test_reset();
      RST_N       = 1'b0;
      REQ_I       = '0;
      ADR_I       = '0;
      LEN_I       = '0;
      MEM_LB_ACK  = 1'b0;
      MEM_LB_WREN = 1'b0;
      MEM_LB_WEND = 1'b0;
      MEM_LB_WDAT = '0;
      exp_q.delete();
      tick();
      tick();
      check_idle_outputs("reset");
      RST_N = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      test_reset();
      setup_port(0, 32'h0000_1000, 8'd4);
      REQ_I = 4'b0001;
      serve(3, 4, 1'b1, 1'b1);
      checks++;
      if (BUSY !== 1'b1) begin
         errors++;
         $display("FAIL basic_gap: BUSY=%b want 1", BUSY);
      end
      tick();
      checks++;
      if (BUSY !== 1'b0) begin
         errors++;
         $display("FAIL basic_idle: BUSY=%b want 0", BUSY);
      end
   endtask

   task automatic test_rotation();
      test_reset();
      for (int p = 0; p < 4; p++) setup_port(p, 32'h2000 + 32'(p) * 32'h100, 8'd2);
      setup_port(0, 32'h2000, 8'd2);
      REQ_I = 4'b1111;
      for (int t = 0; t < 5; t++) serve(1, 2, 1'b1, 1'b0);
      REQ_I = '0;
      repeat (3) tick();
   endtask

   task automatic test_zero_len();
      setup_port(1, 32'h0000_3000, 8'd0);
      REQ_I = 4'b0010;
      serve(0, 0, 1'b0, 1'b1);
      MEM_LB_WREN = 1'b1;
      MEM_LB_WEND = 1'b1;
      #1;
      checks++;
      if (BUSY !== 1'b1 || WREN_O !== '0 || WEND_O !== '0) begin
         errors++;
         $display("FAIL zlen_gap: busy=%b wren=%b wend=%b want 1/0/0", BUSY, WREN_O, WEND_O);
      end
      tick();
      MEM_LB_WREN = 1'b0;
      MEM_LB_WEND = 1'b0;
      checks++;
      if (BUSY !== 1'b0) begin
         errors++;
         $display("FAIL zlen_idle: BUSY=%b want 0", BUSY);
      end
   endtask

   task automatic test_stray();
      MEM_LB_WREN = 1'b1;
      MEM_LB_WEND = 1'b1;
      #1;
      checks++;
      if (WREN_O !== '0 || WEND_O !== '0 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL stray: wren=%b wend=%b busy=%b want 0/0/0", WREN_O, WEND_O, BUSY);
      end
      tick();
      MEM_LB_WREN = 1'b0;
      MEM_LB_WEND = 1'b0;
   endtask

   task automatic test_timeout();
      test_reset();
      setup_port(2, 32'h0000_4000, 8'd3);
      REQ_I = 4'b0100;
      serve(0, 0, 1'b0, 1'b1);
      repeat (TMO - 1) tick();
      checks++;
      if (TMO_ERR !== 1'b0 || WEND_O !== '0) begin
         errors++;
         $display("FAIL tmo_early: tmo=%b wend=%b want 0/0", TMO_ERR, WEND_O);
      end
      tick();
      checks++;
      if (TMO_ERR !== 1'b1 || BUSY !== 1'b1) begin
         errors++;
         $display("FAIL tmo_set: tmo=%b busy=%b want 1/1", TMO_ERR, BUSY);
      end
      tick();
      setup_port(2, 32'h0000_4400, 8'd1);
      REQ_I = 4'b0100;
      serve(0, 1, 1'b1, 1'b1);
      checks++;
      if (TMO_ERR !== 1'b1) begin
         errors++;
         $display("FAIL tmo_sticky: tmo=%b want 1", TMO_ERR);
      end
      tick();
   endtask

   task automatic test_reset_mid_data();
      test_reset();
      setup_port(3, 32'h0000_5000, 8'd8);
      REQ_I = 4'b1000;
      serve(0, 2, 1'b0, 1'b0);
      MEM_LB_WREN = 1'b1;
      MEM_LB_WEND = 1'b1;
      RST_N       = 1'b0;
      #1;
      check_idle_outputs("rst_mid");
      tick();
      MEM_LB_WREN = 1'b0;
      MEM_LB_WEND = 1'b0;
      exp_q.delete();
      setup_port(0, 32'h0000_6000, 8'd1);
      setup_port(3, 32'h0000_5000, 8'd1);
      LEN_I[31:24] = 8'd1;
      REQ_I        = 4'b1001;
      RST_N        = 1'b1;
      serve(0, 1, 1'b1, 1'b1);
      serve(0, 1, 1'b1, 1'b1);
      repeat (3) tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rotation();
      test_zero_len();
      test_stray();
      test_timeout();
      test_reset_mid_data();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: %0d entries left, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
